// File: rtl/hit_tagger_pkg.sv
// Shared widths, record field offsets and record-width helper for the hit tagger.
// The record width depends on HIT_TAGGER_FALLING_EN (adds a leading edge flag bit).
package hit_tagger_pkg;

    localparam int CNT_WIDTH_DEF   = 24;
    localparam int EPOCH_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF  = 16;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DROP_CNT_WIDTH  = 16;

    // Field offsets of a record built with the default widths.
    localparam int CNT_LSB   = 0;
    localparam int EPOCH_LSB = CNT_LSB + CNT_WIDTH_DEF;
    localparam int EDGE_BIT  = EPOCH_LSB + EPOCH_WIDTH_DEF;

    function automatic int rec_width(input int epoch_w, input int cnt_w);
`ifdef HIT_TAGGER_FALLING_EN
        return epoch_w + cnt_w + 1;
`else
        return epoch_w + cnt_w;
`endif
    endfunction

endpackage

// File: rtl/hit_tagger_fifo.sv
// First-word-fall-through FIFO; the head record lives in a register so the output
// holds its last value once the FIFO runs empty.
module tag_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] head_q, head_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_s;
    logic             full_s, empty_s, do_push_s, do_pop_s;

    // Status flags and next pointers / next head record.
    always_comb begin
        level_s   = wr_ptr_q - rd_ptr_q;
        empty_s   = (wr_ptr_q == rd_ptr_q);
        full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push_s = push_i && !full_s;
        do_pop_s  = pop_i && !empty_s;
        wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, do_push_s};
        rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, do_pop_s};
        head_d    = head_q;
        // A push becomes the head when the queue is empty or about to become empty.
        if (do_push_s && (empty_s || (do_pop_s && level_s == {{AW{1'b0}}, 1'b1}))) begin
            head_d = push_data_i;
        end else if (do_pop_s && level_s > {{AW{1'b0}}, 1'b1}) begin
            head_d = mem_q[rd_ptr_d[AW-1:0]];
        end else begin
            head_d = head_q;
        end
    end

    // Record storage; contents are meaningless while the pointers say empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    // Pointer and head register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

    assign rd_data_o = head_q;
    assign full_o    = full_s;
    assign empty_o   = empty_s;
    assign level_o   = level_s;

endmodule

// File: rtl/hit_tagger.sv
// hit_tagger: timestamps hit edges with {epoch, coarse count} and queues them for readout.
// Defining HIT_TAGGER_FALLING_EN also records falling hit edges with a leading edge flag.
module hit_tagger
    import hit_tagger_pkg::*;
#(
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter int EPOCH_WIDTH = EPOCH_WIDTH_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       hit,
    input  logic                                       sync,
    output logic [rec_width(EPOCH_WIDTH, CNT_WIDTH)-1:0] ts_data,
    output logic                                       ts_valid,
    input  logic                                       ts_ready,
    output logic [$clog2(FIFO_DEPTH):0]                level,
    output logic                                       overflow,
    output logic [DROP_CNT_WIDTH-1:0]                  drop_cnt,
    input  logic                                       ovf_clr
);

    localparam int REC_W = rec_width(EPOCH_WIDTH, CNT_WIDTH);

    logic [SYNC_STAGES-1:0]    hit_sync_q, sync_sync_q;
    logic                      hit_dly_q, sync_dly_q;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [EPOCH_WIDTH-1:0]    epoch_q, epoch_d;
    logic                      overflow_q, overflow_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic                      hit_rise_s, sync_ev_s, push_s, drop_s;
    logic                      fifo_full_s, fifo_empty_s;
    logic [REC_W-1:0]          rec_s;
`ifdef HIT_TAGGER_FALLING_EN
    logic                      hit_fall_s;
`endif

    // Synchronizer chains plus one delay flop each for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_sync_q  <= '0;
            sync_sync_q <= '0;
            hit_dly_q   <= 1'b0;
            sync_dly_q  <= 1'b0;
        end else begin
            hit_sync_q  <= {hit_sync_q[SYNC_STAGES-2:0], hit};
            sync_sync_q <= {sync_sync_q[SYNC_STAGES-2:0], sync};
            hit_dly_q   <= hit_sync_q[SYNC_STAGES-1];
            sync_dly_q  <= sync_sync_q[SYNC_STAGES-1];
        end
    end

    // Edge events and the record captured from this cycle's counter values.
    always_comb begin
        hit_rise_s = hit_sync_q[SYNC_STAGES-1] & ~hit_dly_q;
        sync_ev_s  = sync_sync_q[SYNC_STAGES-1] & ~sync_dly_q;
`ifdef HIT_TAGGER_FALLING_EN
        hit_fall_s = ~hit_sync_q[SYNC_STAGES-1] & hit_dly_q;
        push_s     = hit_rise_s | hit_fall_s;
        rec_s      = {hit_rise_s, epoch_q, cnt_q};
`else
        push_s     = hit_rise_s;
        rec_s      = {epoch_q, cnt_q};
`endif
        drop_s     = push_s & fifo_full_s;
    end

    // Coarse counter and epoch; a sync edge takes effect on the following cycle.
    always_comb begin
        cnt_d   = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        epoch_d = epoch_q;
        if (sync_ev_s) begin
            cnt_d   = '0;
            epoch_d = epoch_q + {{(EPOCH_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            epoch_d = epoch_q;
        end
    end

    // Drop bookkeeping; a drop in the clear cycle wins over the clear.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop_s) begin
            overflow_d = 1'b1;
            if (ovf_clr) begin
                drop_cnt_d = {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
            end else if (drop_cnt_q != {DROP_CNT_WIDTH{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            overflow_d = overflow_q;
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Counter, epoch and drop status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            epoch_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            epoch_q    <= epoch_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    tag_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_s),
        .push_data_i (rec_s),
        .pop_i       (ts_ready),
        .rd_data_o   (ts_data),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s),
        .level_o     (level)
    );

    assign ts_valid = ~fifo_empty_s;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_hit_tagger.sv
// Directed self-checking bench for hit_tagger with default parameters.
module tb_hit_tagger;
    import hit_tagger_pkg::*;

`ifdef HIT_TAGGER_FALLING_EN
    localparam int RW = EDGE_BIT + 1;
`else
    localparam int RW = EDGE_BIT;
`endif

    logic          clk, rst_n, hit, sync, ts_valid, ts_ready, overflow, ovf_clr;
    logic [RW-1:0] ts_data;
    logic [4:0]    level;
    logic [15:0]   drop_cnt;
    int            n_cmp, n_bad, tb_cyc, base;

    hit_tagger dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hit      (hit),
        .sync     (sync),
        .ts_data  (ts_data),
        .ts_valid (ts_valid),
        .ts_ready (ts_ready),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .ovf_clr  (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Posedges since reset release; the coarse counter equals this minus base.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    function automatic logic [RW-1:0] rec(input int e, input int c);
        logic [RW-1:0] r;
        r = '0;
        r[EPOCH_LSB +: 8] = e[7:0];
        r[CNT_LSB +: 24]  = c[23:0];
`ifdef HIT_TAGGER_FALLING_EN
        r[EDGE_BIT] = 1'b1;
`endif
        return r;
    endfunction

`ifdef HIT_TAGGER_FALLING_EN
    function automatic logic [RW-1:0] recf(input int e, input int c);
        logic [RW-1:0] r;
        r = '0;
        r[EPOCH_LSB +: 8] = e[7:0];
        r[CNT_LSB +: 24]  = c[23:0];
        return r;
    endfunction
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_to(input int n);
        while (tb_cyc < n) @(negedge clk);
    endtask

    task automatic hit_at(input int h, input int hi);
        wait_to(h);
        hit = 1'b1;
        wait_to(h + hi);
        hit = 1'b0;
    endtask

    task automatic sync_at(input int t);
        wait_to(t);
        sync = 1'b1;
        base = t + 3;
        wait_to(t + 3);
        sync = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [RW-1:0] exp);
        check({tag, "_valid"}, ts_valid, 1);
        check({tag, "_data"}, ts_data, exp);
        ts_ready = 1'b1;
        @(negedge clk);
        ts_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; base = 0;
        rst_n = 1'b0; hit = 1'b0; sync = 1'b0; ts_ready = 1'b0; ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", ts_valid, 0);
        check("rst_level", level, 0);
        check("rst_data", ts_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;
`ifndef HIT_TAGGER_FALLING_EN
        wait_to(3); hit = 1'b1; wait_to(5); hit = 1'b0;
        check("t1_valid_early", ts_valid, 0);
        wait_to(6);
        check("t1_valid", ts_valid, 1);
        check("t1_level", level, 1);
        check("t1_data", ts_data, rec(0, 5));
        ts_ready = 1'b1; @(negedge clk); ts_ready = 1'b0;
        check("t1_empty_valid", ts_valid, 0);
        check("t1_empty_level", level, 0);
        check("t1_hold_data", ts_data, rec(0, 5));

        sync_at(10); hit_at(15, 2); hit_at(20, 2); wait_to(24);
        check("t2_level", level, 2);
        pop_chk("t2_a", rec(1, 4));
        pop_chk("t2_b", rec(1, 9));
        sync_at(30); hit_at(35, 2); wait_to(39);
        pop_chk("t2_c", rec(2, 4));

        sync_at(45);
        wait_to(1046); hit = 1'b1; sync = 1'b1;
        wait_to(1048); hit = 1'b0;
        wait_to(1049); sync = 1'b0; base = 1049;
        check("t3_cnt_zero", dut.cnt_q, 0);
        check("t3_epoch", dut.epoch_q, 4);
        pop_chk("t3_same", rec(3, 1000));
        hit_at(1052, 2); wait_to(1056);
        pop_chk("t3_after", rec(4, 5));

        for (int i = 0; i < 20; i++) hit_at(1060 + 4 * i, 2);
        wait_to(1140);
        check("t4_level", level, 16);
        check("t4_ovf", overflow, 1);
        check("t4_drop", drop_cnt, 4);
        for (int i = 0; i < 16; i++) pop_chk("t4_drain", rec(4, 13 + 4 * i));
        check("t4_drained", ts_valid, 0);
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        check("t4_clr_ovf", overflow, 0);
        check("t4_clr_drop", drop_cnt, 0);

        for (int i = 0; i < 16; i++) hit_at(1160 + 4 * i, 2);
        hit_at(1224, 2);
        ts_ready = 1'b1; @(negedge clk); ts_ready = 1'b0;
        check("t5_level", level, 15);
        check("t5_drop", drop_cnt, 1);
        check("t5_ovf", overflow, 1);
        check("t5_head", ts_data, rec(4, 117));
        hit_at(1228, 2); wait_to(1232);
        check("t5_refull", level, 16);
        hit_at(1232, 2);
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        check("t5_clr_drop_ovf", overflow, 1);
        check("t5_clr_drop_cnt", drop_cnt, 1);
        force dut.drop_cnt_q = 16'hFFFE;
        #1;
        release dut.drop_cnt_q;
        hit_at(1236, 2); hit_at(1240, 2); hit_at(1244, 2); wait_to(1248);
        check("t5_sat", drop_cnt, 16'hFFFF);

        ts_ready = 1'b1; repeat (11) @(negedge clk); ts_ready = 1'b0;
        check("t6_level", level, 5);
        check("t6_head", ts_data, rec(4, 161));
        #2 rst_n = 1'b0;
        #1;
        check("t6_valid", ts_valid, 0);
        check("t6_level_rst", level, 0);
        check("t6_cnt", dut.cnt_q, 0);
        check("t6_epoch", dut.epoch_q, 0);
        @(negedge clk); rst_n = 1'b1; base = 0;
        hit_at(3, 2); wait_to(6);
        pop_chk("t6_fresh", rec(0, 5 - base));
`else
        wait_to(3); hit = 1'b1; wait_to(7); hit = 1'b0; wait_to(11);
        check("f_level", level, 2);
        pop_chk("f_rise", rec(0, 5 - base));
        pop_chk("f_fall", recf(0, 9 - base));
        check("f_empty", ts_valid, 0);
        check("f_ovf", overflow, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
